ex_mem_stage: RTL
=================

// Module: ex_mem_stage
// PURPOSE
//  Parametrised EX->MEM pipeline register, the successor of the fixed 32-bit EX/MEM latch.
//  Carries write-back, HI/LO, aluop, memory-address and store-data payloads, and tags them with a valid bit.
//  Adds a flush input, an explicit RUN/BUBBLE/HOLD state machine, and parametrised multicycle carry state (HILO/cnt).
//  Sits between the ex and mem stages. Driven by the ctrl stall vector and the exception flush.
// PARAMETERS
//  DATA_W   32  width of wdata, hi, lo, mem_addr, reg2
//  RADDR_W   5  register-file address width
//  ALUOP_W   8  aluop width; the reset/bubble value is all-zero (NOP)
//  CNT_W     2  multicycle step-counter width
//  STALL_W   6  width of the ctrl stall vector
//  STAGE     3  stall bit owning this register; stall[STAGE+1] is the downstream bit
//  PERF_W   16  perf-counter width (only with EXMEM_PERF_EN)
// PORTS
//  clk          in   1          rising-edge clock
//  rst          in   1          asynchronous, active-low reset
//  stall        in   STALL_W    ctrl stall vector, 1 = stop
//  flush        in   1          exception flush, 1 = kill the stage contents
//  ex_valid     in   1          EX payload is a real instruction
//  ex_wd        in   RADDR_W    destination register
//  ex_wreg      in   1          register write enable
//  ex_wdata     in   DATA_W     result
//  ex_hi/ex_lo  in   DATA_W     HI/LO write values
//  ex_whilo     in   1          HI/LO write enable
//  ex_aluop     in   ALUOP_W    operation code
//  ex_mem_addr  in   DATA_W     load/store address
//  ex_reg2      in   DATA_W     store data
//  hilo_i       in   2*DATA_W   multicycle partial result from EX
//  cnt_i        in   CNT_W      multicycle step count from EX
//  mem_*        out  (as ex_*)  registered payload, one per ex_* input, including mem_valid
//  hilo_o       out  2*DATA_W   carried partial result back to EX
//  cnt_o        out  CNT_W      carried step count back to EX
//  stage_state  out  2          00 RUN, 01 BUBBLE, 10 HOLD
//  perf_stall   out  PERF_W     HOLD-cycle count (EXMEM_PERF_EN only)
//  perf_bubble  out  PERF_W     BUBBLE-cycle count (EXMEM_PERF_EN only)
// BEHAVIOUR
//  - Reset (rst=0, asynchronous):
//    - all mem_* outputs = 0 (mem_valid=0, mem_aluop=NOP, mem_wreg=0, mem_whilo=0)
//    - hilo_o=0, cnt_o=0, stage_state=RUN, perf counters=0.
//  - Per clk edge, in priority order:
//    1 flush=1: payload = bubble, hilo_o/cnt_o = 0, state -> BUBBLE. Flush overrides any stall.
//    2 stall[STAGE]=1 & stall[STAGE+1]=0: payload = bubble, hilo_o<=hilo_i, cnt_o<=cnt_i, state -> BUBBLE.
//    3 stall[STAGE]=0: payload <= ex_*, hilo_o/cnt_o <= 0, state -> RUN.
//    4 otherwise (both stalled): payload holds, hilo_o<=hilo_i, cnt_o<=cnt_i, state -> HOLD.
//  - Bubble payload: every mem_* output = 0.
//  - Latency: exactly 1 cycle from ex_* to mem_*; no combinational path from input to output.
//  - The valid bit travels with the payload. A loaded payload with ex_valid=0 yields mem_valid=0,
//    but the other fields still load verbatim.
//  - All transitions are legal from any state; the next state depends only on the priority decode above.
//  - stall[STAGE+1]=1 with stall[STAGE]=0 is treated as rule 3; ctrl must never emit it.
//  - STAGE+1 must be < STALL_W; check with an elaboration-time $error.
//  - Reset deasserting mid-stall: the first edge after reset applies the normal decode; no state is retained.
// CONFIGURATION
//  - EXMEM_PERF_EN defined:
//    - perf_stall increments on each edge where the next state is HOLD.
//    - perf_bubble increments on each edge where the next state is BUBBLE.
//    - Both saturate at all-ones and are cleared only by reset.
//  - EXMEM_PERF_EN undefined: perf_stall/perf_bubble are tied to 0 and no counter flops are built.
// TESTING
//  - Reset: pulse rst=0 mid-cycle with a nonzero payload -> all outputs 0 immediately, before the next clk edge.
//  - Pass-through: stall=0, ex_wdata=32'hDEADBEEF, ex_wd=5'd7, ex_wreg=1 -> next edge mem_wdata=DEADBEEF,
//    mem_wd=7, mem_valid=1, stage_state=RUN.
//  - Bubble: stall=6'b001000, hilo_i=64'h1_0000_0002, cnt_i=1 -> mem_* = 0, hilo_o=64'h1_0000_0002, cnt_o=1,
//    stage_state=BUBBLE. Then stall=0 -> hilo_o=0, cnt_o=0.
//  - Hold: load wdata=5, then stall=6'b011000 for 3 cycles -> mem_wdata stays 5, stage_state=HOLD,
//    perf_stall=3 (with PERF_EN).
//  - Flush over stall: stall=6'b011000 and flush=1 together -> mem_valid=0, hilo_o=0, stage_state=BUBBLE.
//  - Saturation: PERF_W=2, hold for 5 cycles -> perf_stall=3 and stays at 3.

Source files
------------

// File: rtl/ex_mem_stage_if.sv
// EX->MEM payload bundle: ex_* payload into the stage, registered mem_* payload out,
// plus the multicycle HILO/cnt carry loop back to EX.
interface ex_mem_stage_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int ALUOP_W = 8,
    parameter int CNT_W   = 2
);
    logic                  ex_valid;
    logic [RADDR_W-1:0]    ex_wd;
    logic                  ex_wreg;
    logic [DATA_W-1:0]     ex_wdata;
    logic [DATA_W-1:0]     ex_hi;
    logic [DATA_W-1:0]     ex_lo;
    logic                  ex_whilo;
    logic [ALUOP_W-1:0]    ex_aluop;
    logic [DATA_W-1:0]     ex_mem_addr;
    logic [DATA_W-1:0]     ex_reg2;
    logic [2*DATA_W-1:0]   hilo_i;
    logic [CNT_W-1:0]      cnt_i;

    logic                  mem_valid;
    logic [RADDR_W-1:0]    mem_wd;
    logic                  mem_wreg;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_hi;
    logic [DATA_W-1:0]     mem_lo;
    logic                  mem_whilo;
    logic [ALUOP_W-1:0]    mem_aluop;
    logic [DATA_W-1:0]     mem_mem_addr;
    logic [DATA_W-1:0]     mem_reg2;
    logic [2*DATA_W-1:0]   hilo_o;
    logic [CNT_W-1:0]      cnt_o;

    // Driver side (EX stage / testbench)
    modport master (
        output ex_valid, ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo,
               ex_aluop, ex_mem_addr, ex_reg2, hilo_i, cnt_i,
        input  mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
               mem_aluop, mem_mem_addr, mem_reg2, hilo_o, cnt_o
    );

    // Pipeline register side
    modport slave (
        input  ex_valid, ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo,
               ex_aluop, ex_mem_addr, ex_reg2, hilo_i, cnt_i,
        output mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
               mem_aluop, mem_mem_addr, mem_reg2, hilo_o, cnt_o
    );
endinterface

// File: rtl/ex_mem_stage.sv
// Parametrised EX->MEM pipeline register with flush, RUN/BUBBLE/HOLD tracking and HILO/cnt carry.
// Optional feature macro: EXMEM_PERF_EN adds saturating HOLD/BUBBLE cycle counters.
module ex_mem_stage #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int ALUOP_W = 8,
    parameter int CNT_W   = 2,
    parameter int STALL_W = 6,
    parameter int STAGE   = 3,
    parameter int PERF_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    ex_mem_stage_if.slave      bus,
    output logic [1:0]         stage_state,
    output logic [PERF_W-1:0]  perf_stall,
    output logic [PERF_W-1:0]  perf_bubble
);

    localparam logic [1:0] ST_RUN    = 2'b00;
    localparam logic [1:0] ST_BUBBLE = 2'b01;
    localparam logic [1:0] ST_HOLD   = 2'b10;

    generate
        if (STAGE + 1 >= STALL_W) begin : g_bad_stage
            $error("ex_mem_stage: STAGE+1 (%0d) must be below STALL_W (%0d)", STAGE + 1, STALL_W);
        end
    endgenerate

    typedef struct packed {
        logic               valid;
        logic [RADDR_W-1:0] wd;
        logic               wreg;
        logic [DATA_W-1:0]  wdata;
        logic [DATA_W-1:0]  hi;
        logic [DATA_W-1:0]  lo;
        logic               whilo;
        logic [ALUOP_W-1:0] aluop;
        logic [DATA_W-1:0]  mem_addr;
        logic [DATA_W-1:0]  reg2;
    } payload_t;

    payload_t            ex_payload;
    payload_t            payload_d, payload_q;
    logic [2*DATA_W-1:0] hilo_d, hilo_q;
    logic [CNT_W-1:0]    cnt_d, cnt_q;
    logic [1:0]          state_d, state_q;
    logic                own_stall, down_stall;
    logic                stall_unused;

    assign own_stall    = stall[STAGE];
    assign down_stall   = stall[STAGE+1];
    assign stall_unused = ^stall;

    assign ex_payload = {bus.ex_valid, bus.ex_wd, bus.ex_wreg, bus.ex_wdata, bus.ex_hi,
                         bus.ex_lo, bus.ex_whilo, bus.ex_aluop, bus.ex_mem_addr, bus.ex_reg2};

    // Priority: flush, drain into a bubble, load, hold. The bubble payload is all-zero (aluop = NOP).
    always_comb begin
        payload_d = payload_q;
        hilo_d    = hilo_q;
        cnt_d     = cnt_q;
        state_d   = state_q;
        if (flush) begin
            payload_d = '0;
            hilo_d    = '0;
            cnt_d     = '0;
            state_d   = ST_BUBBLE;
        end else if (own_stall && !down_stall) begin
            payload_d = '0;
            hilo_d    = bus.hilo_i;
            cnt_d     = bus.cnt_i;
            state_d   = ST_BUBBLE;
        end else if (!own_stall) begin
            payload_d = ex_payload;
            hilo_d    = '0;
            cnt_d     = '0;
            state_d   = ST_RUN;
        end else begin
            hilo_d    = bus.hilo_i;
            cnt_d     = bus.cnt_i;
            state_d   = ST_HOLD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            payload_q <= '0;
            hilo_q    <= '0;
            cnt_q     <= '0;
            state_q   <= ST_RUN;
        end else begin
            payload_q <= payload_d;
            hilo_q    <= hilo_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
        end
    end

    assign bus.mem_valid    = payload_q.valid;
    assign bus.mem_wd       = payload_q.wd;
    assign bus.mem_wreg     = payload_q.wreg;
    assign bus.mem_wdata    = payload_q.wdata;
    assign bus.mem_hi       = payload_q.hi;
    assign bus.mem_lo       = payload_q.lo;
    assign bus.mem_whilo    = payload_q.whilo;
    assign bus.mem_aluop    = payload_q.aluop;
    assign bus.mem_mem_addr = payload_q.mem_addr;
    assign bus.mem_reg2     = payload_q.reg2;
    assign bus.hilo_o       = hilo_q;
    assign bus.cnt_o        = cnt_q;
    assign stage_state      = state_q;

`ifdef EXMEM_PERF_EN
    logic [PERF_W-1:0] perf_stall_d, perf_stall_q;
    logic [PERF_W-1:0] perf_bubble_d, perf_bubble_q;

    // Counters look at the state being entered and stick at all-ones until reset.
    always_comb begin
        perf_stall_d  = perf_stall_q;
        perf_bubble_d = perf_bubble_q;
        if (state_d == ST_HOLD && perf_stall_q != '1) begin
            perf_stall_d = perf_stall_q + 1'b1;
        end
        if (state_d == ST_BUBBLE && perf_bubble_q != '1) begin
            perf_bubble_d = perf_bubble_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q  <= '0;
            perf_bubble_q <= '0;
        end else begin
            perf_stall_q  <= perf_stall_d;
            perf_bubble_q <= perf_bubble_d;
        end
    end

    assign perf_stall  = perf_stall_q;
    assign perf_bubble = perf_bubble_q;
`else
    assign perf_stall  = '0;
    assign perf_bubble = '0;
`endif

endmodule
